// File: rtl/repeat_time_down.sv
// ---------------------------------------------------------------------------
// repeat_time_down
//   Programmable down-counting timer. A start pulse latches cfg_max_i and the
//   mode, loads the counter with cfg_max_i and counts down to zero. The edge
//   that sees zero while running produces a registered one-cycle timeout
//   pulse and bumps the completed-period counter. In repeat mode the counter
//   reloads from the latched value and keeps running. In one-shot mode it
//   parks in DONE with the counter at zero.
//
// Handshake / control semantics (all sampled on the rising edge of clk_i):
//   rst_i > en_i==0 > start_i > pause_i > normal counting. start_i is a level
//   sampled every edge, so a one-cycle pulse gives one (re)start. No
//   valid/ready pairs are used. Outputs are all registered.
//
// Ports
//   clk_i       system clock, rising edge
//   rst_i       synchronous reset, active-high
//   en_i        enable; 0 forces IDLE, clears cnt/periods, ignores start
//   start_i     latch cfg_max_i/mode_i and (re)start the countdown
//   pause_i     hold cnt, periods and state while running
//   mode_i      0 = one-shot, 1 = repeat (sampled only with start_i)
//   cfg_max_i   reload value; one period is cfg_max_i+1 cycles
//   cnt_o       current count
//   timeout_o   one-cycle pulse when a countdown completes
//   busy_o      1 while running (including paused)
//   done_o      1 while parked after a one-shot countdown
//   periods_o   completed countdowns since the last start (wraps)
//   state_o     debug view of the FSM state (0 IDLE, 1 RUN, 2 DONE)
// ---------------------------------------------------------------------------
module repeat_time_down #(
  parameter int WIDTH  = 32,
  parameter int PWIDTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              start_i,
  input  logic              pause_i,
  input  logic              mode_i,
  input  logic [WIDTH-1:0]  cfg_max_i,
  output logic [WIDTH-1:0]  cnt_o,
  output logic              timeout_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [PWIDTH-1:0] periods_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q,   state_d;
  logic [WIDTH-1:0]    cnt_q,     cnt_d;
  logic                timeout_q, timeout_d;
  logic [PWIDTH-1:0]   periods_q, periods_d;
  logic [WIDTH-1:0]    cfg_lat_q, cfg_lat_d;
  logic                mode_lat_q, mode_lat_d;
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;

  // -------------------------------------------------------------------------
  // Next-state / datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;          // pulse: only asserted on a completing edge
    periods_d  = periods_q;
    cfg_lat_d  = cfg_lat_q;
    mode_lat_d = mode_lat_q;

    if (!en_i) begin
      // Disable wins over start; the latched config is kept but unused
      // until the next start reloads it.
      state_d   = S_IDLE;
      cnt_d     = '0;
      periods_d = '0;
    end else if (start_i) begin
      // Same restart from any state; a restart never emits a timeout even
      // if the running count happened to be zero.
      state_d    = S_RUN;
      cnt_d      = cfg_max_i;
      cfg_lat_d  = cfg_max_i;
      mode_lat_d = mode_i;
      periods_d  = '0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (!pause_i) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - WIDTH'(1);
            end else begin
              timeout_d = 1'b1;
              periods_d = periods_q + PWIDTH'(1);
              if (mode_lat_q) begin
                // Reload so the next timeout lands cfg_lat+1 edges later.
                cnt_d = cfg_lat_q;
              end else begin
                cnt_d   = '0;
                state_d = S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          cnt_d = '0;
        end
        S_IDLE: begin
          cnt_d = cnt_q;
        end
        default: begin
          // Unreachable encoding: recover to a clean idle.
          state_d   = S_IDLE;
          cnt_d     = '0;
          periods_d = '0;
        end
      endcase
    end

    // Status flags are decoded from the next state so they register in
    // step with the state they describe.
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
      periods_q  <= '0;
      cfg_lat_q  <= '0;
      mode_lat_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
      periods_q  <= periods_d;
      cfg_lat_q  <= cfg_lat_d;
      mode_lat_q <= mode_lat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign timeout_o = timeout_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign periods_o = periods_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_repeat_time_down.sv
// ---------------------------------------------------------------------------
// tb_repeat_time_down
//   Table-driven bench for repeat_time_down. Each record holds the inputs
//   for one clock edge and the outputs expected just after that edge.
//   A hand-written sequence afterwards exercises cfg_max=0 repeat mode
//   through a wrap of the (narrowed) period counter.
// ---------------------------------------------------------------------------
module tb_repeat_time_down;

  localparam int W  = 32;
  localparam int PW = 4;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, start, pause, mode;
  logic [W-1:0]  cfg_max;
  logic [W-1:0]  cnt;
  logic          timeout, busy, done;
  logic [PW-1:0] periods;
  logic [1:0]    state_dbg;

  repeat_time_down #(.WIDTH(W), .PWIDTH(PW)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .start_i   (start),
    .pause_i   (pause),
    .mode_i    (mode),
    .cfg_max_i (cfg_max),
    .cnt_o     (cnt),
    .timeout_o (timeout),
    .busy_o    (busy),
    .done_o    (done),
    .periods_o (periods),
    .state_o   (state_dbg)
  );

  typedef struct {
    logic          rst, en, start, pause, mode;
    logic [W-1:0]  cfg;
    logic [W-1:0]  cnt;
    logic          to, busy, done;
    logic [PW-1:0] per;
  } vec_t;

  vec_t vq[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t v(input int r, input int e, input int s, input int p,
                             input int m, input int cfg, input int c, input int t,
                             input int b, input int d, input int per);
    vec_t x;
    x.rst = r[0]; x.en = e[0]; x.start = s[0]; x.pause = p[0]; x.mode = m[0];
    x.cfg = W'(cfg); x.cnt = W'(c);
    x.to = t[0]; x.busy = b[0]; x.done = d[0]; x.per = PW'(per);
    return x;
  endfunction

  // Plain running edge; cfg_max=7 / mode=0 are deliberately noise that the
  // DUT must ignore outside a start.
  function automatic vec_t r(input int c, input int t, input int b, input int d,
                             input int per);
    return v(0, 1, 0, 0, 0, 7, c, t, b, d, per);
  endfunction

  function automatic vec_t pz(input int c, input int per);
    return v(0, 1, 0, 1, 0, 7, c, 0, 1, 0, per);
  endfunction

  // driver + scoreboard check for one edge
  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    rst = t.rst; en = t.en; start = t.start; pause = t.pause;
    mode = t.mode; cfg_max = t.cfg;
    @(posedge clk);
    #1;
    n_vec++;
    if (cnt !== t.cnt || timeout !== t.to || busy !== t.busy ||
        done !== t.done || periods !== t.per) begin
      n_miss++;
      $display("FAIL %s: got cnt=%0d to=%b busy=%b done=%b per=%0d, want cnt=%0d to=%b busy=%b done=%b per=%0d",
               tag, cnt, timeout, busy, done, periods,
               t.cnt, t.to, t.busy, t.done, t.per);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; pause = 1'b0; mode = 1'b0;
    cfg_max = '0;

    // reset state
    vq.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // repeat, cfg_max=3: timeouts 4, 8, 12 edges after start
    vq.push_back(v(0, 1, 1, 0, 1, 3, 3, 0, 1, 0, 0));
    vq.push_back(r(2,0,1,0,0)); vq.push_back(r(1,0,1,0,0)); vq.push_back(r(0,0,1,0,0));
    vq.push_back(r(3,1,1,0,1)); vq.push_back(r(2,0,1,0,1)); vq.push_back(r(1,0,1,0,1));
    vq.push_back(r(0,0,1,0,1)); vq.push_back(r(3,1,1,0,2)); vq.push_back(r(2,0,1,0,2));
    vq.push_back(r(1,0,1,0,2)); vq.push_back(r(0,0,1,0,2)); vq.push_back(r(3,1,1,0,3));

    // one-shot, cfg_max=2, restarted from RUN; then DONE held 10 cycles
    vq.push_back(v(0, 1, 1, 0, 0, 2, 2, 0, 1, 0, 0));
    vq.push_back(r(1,0,1,0,0)); vq.push_back(r(0,0,1,0,0)); vq.push_back(r(0,1,0,1,1));
    for (int i = 0; i < 10; i++) vq.push_back(r(0,0,0,1,1));

    // repeat, cfg_max=5, started from DONE, paused 3 cycles at cnt=4
    vq.push_back(v(0, 1, 1, 0, 1, 5, 5, 0, 1, 0, 0));
    vq.push_back(r(4,0,1,0,0));
    vq.push_back(pz(4,0)); vq.push_back(pz(4,0)); vq.push_back(pz(4,0));
    vq.push_back(r(3,0,1,0,0)); vq.push_back(r(2,0,1,0,0)); vq.push_back(r(1,0,1,0,0));
    vq.push_back(r(0,0,1,0,0)); vq.push_back(r(5,1,1,0,1));
    // pause while sitting at zero suppresses the timeout
    vq.push_back(r(4,0,1,0,1)); vq.push_back(r(3,0,1,0,1)); vq.push_back(r(2,0,1,0,1));
    vq.push_back(r(1,0,1,0,1)); vq.push_back(r(0,0,1,0,1));
    vq.push_back(pz(0,1)); vq.push_back(pz(0,1));
    vq.push_back(r(5,1,1,0,2));

    // restart: cfg_max=9, then at cnt=5 restart with cfg_max=1
    vq.push_back(v(0, 1, 1, 0, 1, 9, 9, 0, 1, 0, 0));
    vq.push_back(r(8,0,1,0,0)); vq.push_back(r(7,0,1,0,0));
    vq.push_back(r(6,0,1,0,0)); vq.push_back(r(5,0,1,0,0));
    vq.push_back(v(0, 1, 1, 0, 1, 1, 1, 0, 1, 0, 0));
    vq.push_back(r(0,0,1,0,0)); vq.push_back(r(1,1,1,0,1));
    vq.push_back(r(0,0,1,0,1)); vq.push_back(r(1,1,1,0,2));
    // en=0 clears periods; start with en=0 ignored; IDLE holds
    vq.push_back(v(0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 1, 0, 1, 9, 0, 0, 0, 0, 0));
    vq.push_back(r(0,0,0,0,0));

    // en=0 mid-run at cnt=7
    vq.push_back(v(0, 1, 1, 0, 1, 9, 9, 0, 1, 0, 0));
    vq.push_back(r(8,0,1,0,0)); vq.push_back(r(7,0,1,0,0));
    vq.push_back(v(0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0));
    // rst mid-run at cnt=7, overriding a simultaneous start
    vq.push_back(v(0, 1, 1, 0, 1, 9, 9, 0, 1, 0, 0));
    vq.push_back(r(8,0,1,0,0)); vq.push_back(r(7,0,1,0,0));
    vq.push_back(v(1, 1, 1, 0, 1, 9, 0, 0, 0, 0, 0));
    vq.push_back(r(0,0,0,0,0));

    // one-shot cfg_max=0: single timeout then DONE; en=0 leaves DONE
    vq.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    vq.push_back(r(0,1,0,1,1)); vq.push_back(r(0,0,0,1,1));
    vq.push_back(v(0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0));

    for (int i = 0; i < vq.size(); i++) apply(vq[i], $sformatf("vec%0d", i));

    // repeat cfg_max=0: timeout every edge, periods wraps after 2^PW
    apply(v(0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0), "zero_start");
    for (int i = 1; i <= 20; i++)
      apply(v(0, 1, 0, 0, 0, 5, 0, 1, 1, 0, i % (1 << PW)), $sformatf("zero_rep%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
